// File: rtl/spu_reg_file_if.sv
// Bus bundle between decode/issue, the two write-back stages and the SPU
// register file: WB write ports, three source read ports, issue scoreboard
// controls and the stall/conflict status returned to the pipeline.
interface spu_reg_file_if #(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 7
);
    // even-pipe write-back
    logic              wr_en_e;
    logic [ADDR_W-1:0] wr_tgt_e;
    logic [WIDTH-1:0]  wr_val_e;
    // odd-pipe write-back
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_tgt_o;
    logic [WIDTH-1:0]  wr_val_o;
    // source operand read ports
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_use_a;
    logic              rd_use_b;
    logic              rd_use_c;
    logic [WIDTH-1:0]  rd_val_a;
    logic [WIDTH-1:0]  rd_val_b;
    logic [WIDTH-1:0]  rd_val_c;
    // issue / scoreboard
    logic              iss_valid;
    logic              iss_wr;
    logic [ADDR_W-1:0] iss_tgt;
    logic              issue_stall;
    logic              wr_conflict;

    // pipeline side: drives writes, reads and issue requests
    modport master (
        output wr_en_e, wr_tgt_e, wr_val_e,
        output wr_en_o, wr_tgt_o, wr_val_o,
        output rd_addr_a, rd_addr_b, rd_addr_c,
        output rd_use_a, rd_use_b, rd_use_c,
        output iss_valid, iss_wr, iss_tgt,
        input  rd_val_a, rd_val_b, rd_val_c,
        input  issue_stall, wr_conflict
    );

    // register file side
    modport slave (
        input  wr_en_e, wr_tgt_e, wr_val_e,
        input  wr_en_o, wr_tgt_o, wr_val_o,
        input  rd_addr_a, rd_addr_b, rd_addr_c,
        input  rd_use_a, rd_use_b, rd_use_c,
        input  iss_valid, iss_wr, iss_tgt,
        output rd_val_a, rd_val_b, rd_val_c,
        output issue_stall, wr_conflict
    );
endinterface

// File: rtl/spu_reg_file.sv
// SPU architectural register file.
// - Two write-back ports (even/odd pipe); the odd port wins on a same-target
//   collision, which is also recorded in the sticky wr_conflict flag.
// - Three combinational read ports with same-cycle write bypass, using the
//   same odd-over-even priority so bypassed and stored values always agree.
// - Per-register busy scoreboard: accepted issues mark their target pending,
//   write-backs clear it; a set in the same cycle as a clear wins.
// - issue_stall flags an issue whose used source is pending and not being
//   written back this very cycle.
module spu_reg_file #(
    parameter int NUM_REGS = 128,
    parameter int WIDTH    = 128,
    parameter int ADDR_W   = 7
) (
    input  logic           clock,
    input  logic           reset,
    spu_reg_file_if.slave  bus
);

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------

    // true when an enabled write-back port targets the given register
    function automatic logic wb_hit(
        input logic              en,
        input logic [ADDR_W-1:0] tgt,
        input logic [ADDR_W-1:0] addr
    );
        return en && (tgt == addr);
    endfunction

    // read-port value: odd WB, then even WB, then stored entry
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              en_e,
        input logic [ADDR_W-1:0] tgt_e,
        input logic [WIDTH-1:0]  val_e,
        input logic              en_o,
        input logic [ADDR_W-1:0] tgt_o,
        input logic [WIDTH-1:0]  val_o
    );
        logic [WIDTH-1:0] res;
        if (wb_hit(en_o, tgt_o, addr)) begin
            res = val_o;
        end else if (wb_hit(en_e, tgt_e, addr)) begin
            res = val_e;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // state and internal signals
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    mem_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic                wr_conflict_r;

    logic                wr_en_e_s;
    logic                wr_en_o_s;
    logic                iss_valid_s;
    logic                clear_a_s;
    logic                clear_b_s;
    logic                clear_c_s;
    logic                stall_a_s;
    logic                stall_b_s;
    logic                stall_c_s;
    logic                issue_stall_s;
    logic                iss_accept_s;
    logic                conflict_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [WIDTH-1:0]    rd_val_a_s;
    logic [WIDTH-1:0]    rd_val_b_s;
    logic [WIDTH-1:0]    rd_val_c_s;

    // Qualify write-back and issue requests with reset so that nothing
    // presented while reset is high can be written, bypassed or stalled on.
    always_comb begin
        wr_en_e_s   = bus.wr_en_e   & ~reset;
        wr_en_o_s   = bus.wr_en_o   & ~reset;
        iss_valid_s = bus.iss_valid & ~reset;
        conflict_s  = wr_en_e_s & wr_en_o_s & (bus.wr_tgt_e == bus.wr_tgt_o);
    end

    // Read ports with same-cycle write-back bypass.
    always_comb begin
        rd_val_a_s = read_port(bus.rd_addr_a, mem_r[bus.rd_addr_a],
                               wr_en_e_s, bus.wr_tgt_e, bus.wr_val_e,
                               wr_en_o_s, bus.wr_tgt_o, bus.wr_val_o);
        rd_val_b_s = read_port(bus.rd_addr_b, mem_r[bus.rd_addr_b],
                               wr_en_e_s, bus.wr_tgt_e, bus.wr_val_e,
                               wr_en_o_s, bus.wr_tgt_o, bus.wr_val_o);
        rd_val_c_s = read_port(bus.rd_addr_c, mem_r[bus.rd_addr_c],
                               wr_en_e_s, bus.wr_tgt_e, bus.wr_val_e,
                               wr_en_o_s, bus.wr_tgt_o, bus.wr_val_o);
    end

    // Source-operand hazard check; an operand being written back right now
    // is delivered through the bypass and must not stall.
    always_comb begin
        clear_a_s = wb_hit(wr_en_e_s, bus.wr_tgt_e, bus.rd_addr_a) |
                    wb_hit(wr_en_o_s, bus.wr_tgt_o, bus.rd_addr_a);
        clear_b_s = wb_hit(wr_en_e_s, bus.wr_tgt_e, bus.rd_addr_b) |
                    wb_hit(wr_en_o_s, bus.wr_tgt_o, bus.rd_addr_b);
        clear_c_s = wb_hit(wr_en_e_s, bus.wr_tgt_e, bus.rd_addr_c) |
                    wb_hit(wr_en_o_s, bus.wr_tgt_o, bus.rd_addr_c);
        stall_a_s = bus.rd_use_a & busy_r[bus.rd_addr_a] & ~clear_a_s;
        stall_b_s = bus.rd_use_b & busy_r[bus.rd_addr_b] & ~clear_b_s;
        stall_c_s = bus.rd_use_c & busy_r[bus.rd_addr_c] & ~clear_c_s;
        issue_stall_s = iss_valid_s & (stall_a_s | stall_b_s | stall_c_s);
        iss_accept_s  = iss_valid_s & bus.iss_wr & ~issue_stall_s;
    end

    // Next scoreboard state: clear write-back targets, then set the accepted
    // issue target so a new producer outranks a retiring one.
    always_comb begin
        clr_mask_s = {NUM_REGS{1'b0}};
        set_mask_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            clr_mask_s[i] = wb_hit(wr_en_e_s, bus.wr_tgt_e, ADDR_W'(i)) |
                            wb_hit(wr_en_o_s, bus.wr_tgt_o, ADDR_W'(i));
            set_mask_s[i] = iss_accept_s & (bus.iss_tgt == ADDR_W'(i));
        end
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Register storage; the odd-port write is issued last so it wins a
    // same-target collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_en_e_s) begin
                mem_r[bus.wr_tgt_e] <= bus.wr_val_e;
            end
            if (wr_en_o_s) begin
                mem_r[bus.wr_tgt_o] <= bus.wr_val_o;
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Sticky record of a same-target write-back collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_conflict_r <= 1'b0;
        end else if (conflict_s) begin
            wr_conflict_r <= 1'b1;
        end
    end

    assign bus.rd_val_a    = rd_val_a_s;
    assign bus.rd_val_b    = rd_val_b_s;
    assign bus.rd_val_c    = rd_val_c_s;
    assign bus.issue_stall = issue_stall_s;
    assign bus.wr_conflict = wr_conflict_r;

endmodule
